// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forwarding selects, hazard controller states, x0 constant.
package pipeline_pkg;

  localparam int unsigned REG_X0 = 0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    FREEZE = 2'b10
  } hz_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight writer counters; pending is combinational, with same-cycle WB retire netted out.
// Counters update on the clock edge when updEn is set and saturate at both ends.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int SB_CW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              updEn,
  input  logic              issueVld,
  input  logic [REG_AW-1:0] issueRd,
  input  logic              retireVld,
  input  logic [REG_AW-1:0] retireRd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rs1Pend,
  output logic              rs2Pend
);

  localparam int NREG = 2 ** REG_AW;
  localparam logic [SB_CW-1:0] CNT_MAX = '1;

  logic [SB_CW-1:0] cnt [NREG];
  logic             ret1Hit;
  logic             ret2Hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (updEn) begin
      for (int r = 0; r < NREG; r++) begin
        // Issue and retire on the same register cancel out
        if (issueVld && issueRd == REG_AW'(r) && !(retireVld && retireRd == REG_AW'(r))) begin
          if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + 1'b1;
        end else if (retireVld && retireRd == REG_AW'(r) && !(issueVld && issueRd == REG_AW'(r))) begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  assign ret1Hit = retireVld && (retireRd == rs1);
  assign ret2Hit = retireVld && (retireRd == rs2);
  assign rs1Pend = cnt[rs1] > SB_CW'(ret1Hit);
  assign rs2Pend = cnt[rs2] > SB_CW'(ret2Hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: priority reset > freeze > redirect > stall > run; enables are combinational, fwd_a/fwd_b registered (1 cycle).
// Build option HAZARD_FORWARDING_EN selects EXE bypass with load-use stalls; otherwise a scoreboard interlock is used.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int SB_CW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_use,
  input  logic              id_rs2_use,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_we,
  input  logic [REG_AW-1:0] exe_rd,
  input  logic              exe_reg_we,
  input  logic              exe_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_we,
  input  logic              br_taken,
  input  logic              dmem_busy,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              if_id_flush,
  output logic              id_exe_flush,
  output logic              pipe_hold,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_X0);

  hz_state_t state;
  hz_state_t stateNxt;
  logic      rs1Live;
  logic      rs2Live;
  logic      dataHaz;
  logic      unusedOk;

  assign rs1Live = id_rs1_use && (id_rs1 != X0);
  assign rs2Live = id_rs2_use && (id_rs2 != X0);

`ifdef HAZARD_FORWARDING_EN
  fwd_sel_t fwdA;
  fwd_sel_t fwdB;
  logic     exeLoadHit;

  function automatic fwd_sel_t selFor(input logic [REG_AW-1:0] rs, input logic live);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (live && exe_reg_we && exe_rd == rs && !exe_is_load) sel = FWD_MEM;
    else if (live && mem_reg_we && mem_rd == rs) sel = FWD_WB;
    return sel;
  endfunction

  assign exeLoadHit = exe_reg_we && exe_is_load && (exe_rd != X0);
  assign dataHaz    = exeLoadHit && ((rs1Live && exe_rd == id_rs1) || (rs2Live && exe_rd == id_rs2));

  always_ff @(posedge clk) begin
    if (!rst) begin
      fwdA <= FWD_RF;
      fwdB <= FWD_RF;
    end else if (dmem_busy) begin
      fwdA <= fwdA;
      fwdB <= fwdB;
    end else if (br_taken || dataHaz) begin
      fwdA <= FWD_RF;
      fwdB <= FWD_RF;
    end else begin
      fwdA <= selFor(id_rs1, rs1Live);
      fwdB <= selFor(id_rs2, rs2Live);
    end
  end

  assign fwd_a    = fwdA;
  assign fwd_b    = fwdB;
  assign unusedOk = ^{id_rd, id_reg_we, wb_rd, wb_reg_we, state, {SB_CW{1'b0}}};
`else
  logic rs1Pend;
  logic rs2Pend;
  logic issueVld;
  logic retireVld;

  // An instruction leaves ID only in a plain RUN cycle
  assign issueVld  = rst && !dmem_busy && !br_taken && !dataHaz && id_reg_we && (id_rd != X0);
  assign retireVld = wb_reg_we && (wb_rd != X0);
  assign dataHaz   = (rs1Live && rs1Pend) || (rs2Live && rs2Pend);

  hazard_scoreboard #(
    .REG_AW(REG_AW),
    .SB_CW (SB_CW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .updEn    (!dmem_busy),
    .issueVld (issueVld),
    .issueRd  (id_rd),
    .retireVld(retireVld),
    .retireRd (wb_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1Pend  (rs1Pend),
    .rs2Pend  (rs2Pend)
  );

  assign fwd_a    = FWD_RF;
  assign fwd_b    = FWD_RF;
  assign unusedOk = ^{exe_rd, exe_reg_we, exe_is_load, mem_rd, mem_reg_we, state};
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt     = RUN;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    pipe_hold    = 1'b0;
    if (!rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (dmem_busy) begin
      stateNxt  = FREEZE;
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      pipe_hold = 1'b1;
    end else if (br_taken) begin
      // The ID instruction is killed, so any hazard it had is moot
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (dataHaz) begin
      stateNxt     = STALL;
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_exe_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; covers the scoreboard build by default and the forwarding build under HAZARD_FORWARDING_EN.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_rd, exe_rd, mem_rd, wb_rd;
  logic       id_rs1_use, id_rs2_use, id_reg_we, exe_reg_we, exe_is_load;
  logic       mem_reg_we, wb_reg_we, br_taken, dmem_busy;
  logic       pc_we, if_id_we, if_id_flush, id_exe_flush, pipe_hold;
  logic [1:0] fwd_a, fwd_b;

  int total = 0;
  int bad   = 0;

  // {pc_we, if_id_we, if_id_flush, id_exe_flush, pipe_hold}
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_FRZ   = 5'b00001;
  localparam logic [4:0] C_RST   = 5'b00110;
  // {pc_we, if_id_flush, id_exe_flush, pipe_hold}
  localparam logic [3:0] C_REDIR = 4'b1110;

  wire [4:0] ctl   = {pc_we, if_id_we, if_id_flush, id_exe_flush, pipe_hold};
  wire [3:0] redir = {pc_we, if_id_flush, id_exe_flush, pipe_hold};

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_reg_we(id_reg_we),
    .exe_rd(exe_rd), .exe_reg_we(exe_reg_we), .exe_is_load(exe_is_load),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
    .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
    .br_taken(br_taken), .dmem_busy(dmem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_exe_flush(id_exe_flush), .pipe_hold(pipe_hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0; id_rd = 0; id_reg_we = 0;
    exe_rd = 0; exe_reg_we = 0; exe_is_load = 0; mem_rd = 0; mem_reg_we = 0;
    wb_rd = 0; wb_reg_we = 0; br_taken = 0; dmem_busy = 0;
  endtask

  task automatic test_reset;
    rst = 1'b0; clear_in();
    tick(); tick();
    total++; if (ctl !== C_RST) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_RST); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL reset_fwd_a got=%b want=00", fwd_a); end
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL reset_fwd_b got=%b want=00", fwd_b); end
    rst = 1'b1;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL reset_release got=%b want=%b", ctl, C_RUN); end
    tick();
  endtask

  task automatic test_x0;
    clear_in(); id_rd = 0; id_reg_we = 1; exe_rd = 0; exe_reg_we = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL x0_issue got=%b want=%b", ctl, C_RUN); end
    tick();
    clear_in(); id_rs1 = 0; id_rs1_use = 1; exe_rd = 0; exe_reg_we = 1; exe_is_load = 1; mem_rd = 0; mem_reg_we = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL x0_use got=%b want=%b", ctl, C_RUN); end
    tick();
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL x0_fwd_a got=%b want=00", fwd_a); end
  endtask

`ifndef HAZARD_FORWARDING_EN
  task automatic test_sb_raw;
    clear_in(); id_rd = 5; id_reg_we = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL raw_issue got=%b want=%b", ctl, C_RUN); end
    tick();
    clear_in(); id_rs1 = 5; id_rs1_use = 1; exe_rd = 5; exe_reg_we = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL raw_stall1 got=%b want=%b", ctl, C_STALL); end
    tick();
    clear_in(); id_rs1 = 5; id_rs1_use = 1; mem_rd = 5; mem_reg_we = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL raw_stall2 got=%b want=%b", ctl, C_STALL); end
    tick();
    clear_in(); id_rs1 = 5; id_rs1_use = 1; wb_rd = 5; wb_reg_we = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL raw_wb_issue got=%b want=%b", ctl, C_RUN); end
    tick();
    clear_in(); id_rs2 = 5; id_rs2_use = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL raw_cnt_zero got=%b want=%b", ctl, C_RUN); end
    tick();
  endtask

  task automatic test_sb_freeze;
    clear_in(); id_rd = 6; id_reg_we = 1; dmem_busy = 1; #1;
    total++; if (ctl !== C_FRZ) begin bad++; $display("FAIL frz_ctl got=%b want=%b", ctl, C_FRZ); end
    tick();
    clear_in(); id_rs1 = 6; id_rs1_use = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL frz_no_issue got=%b want=%b", ctl, C_RUN); end
    tick();
    clear_in(); id_rd = 7; id_reg_we = 1; tick();
    clear_in(); wb_rd = 7; wb_reg_we = 1; dmem_busy = 1; id_rs1 = 7; id_rs1_use = 1; #1;
    total++; if (ctl !== C_FRZ) begin bad++; $display("FAIL frz_over_haz got=%b want=%b", ctl, C_FRZ); end
    tick();
    clear_in(); id_rs1 = 7; id_rs1_use = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL frz_no_retire got=%b want=%b", ctl, C_STALL); end
    wb_rd = 7; wb_reg_we = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL frz_retire got=%b want=%b", ctl, C_RUN); end
    tick();
  endtask

  task automatic test_sb_redirect;
    clear_in(); id_rd = 8; id_reg_we = 1; tick();
    clear_in(); id_rs1 = 8; id_rs1_use = 1; id_rd = 9; id_reg_we = 1; br_taken = 1; #1;
    total++; if (redir !== C_REDIR) begin bad++; $display("FAIL redir_ctl got=%b want=%b", redir, C_REDIR); end
    tick();
    clear_in(); id_rs2 = 9; id_rs2_use = 1; wb_rd = 8; wb_reg_we = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL redir_killed got=%b want=%b", ctl, C_RUN); end
    tick();
  endtask

  task automatic test_sb_saturate;
    for (int i = 0; i < 4; i++) begin
      clear_in(); id_rd = 9; id_reg_we = 1; tick();
    end
    clear_in(); id_rs1 = 9; id_rs1_use = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL sat_max got=%b want=%b", ctl, C_STALL); end
    tick();
    for (int i = 0; i < 2; i++) begin
      clear_in(); wb_rd = 9; wb_reg_we = 1; tick();
    end
    clear_in(); id_rs1 = 9; id_rs1_use = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL sat_one_left got=%b want=%b", ctl, C_STALL); end
    wb_rd = 9; wb_reg_we = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL sat_last_retire got=%b want=%b", ctl, C_RUN); end
    tick();
    clear_in(); id_rs1 = 9; id_rs1_use = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL sat_empty got=%b want=%b", ctl, C_RUN); end
    tick();
  endtask

  task automatic test_sb_underflow;
    clear_in(); wb_rd = 10; wb_reg_we = 1; tick(); tick();
    clear_in(); id_rs1 = 10; id_rs1_use = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL underflow got=%b want=%b", ctl, C_RUN); end
    tick();
  endtask

  task automatic test_sb_simul;
    clear_in(); id_rd = 11; id_reg_we = 1; tick();
    clear_in(); id_rd = 11; id_reg_we = 1; wb_rd = 11; wb_reg_we = 1; tick();
    clear_in(); id_rs2 = 11; id_rs2_use = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL simul_hold got=%b want=%b", ctl, C_STALL); end
    tick();
    clear_in(); id_rs2 = 11; id_rs2_use = 1; wb_rd = 11; wb_reg_we = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL simul_retire got=%b want=%b", ctl, C_RUN); end
    tick();
  endtask

  task automatic test_reset_abort;
    clear_in(); id_rd = 12; id_reg_we = 1; tick();
    clear_in(); id_rs1 = 12; id_rs1_use = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL abort_stall got=%b want=%b", ctl, C_STALL); end
    rst = 1'b0; #1;
    total++; if (ctl !== C_RST) begin bad++; $display("FAIL abort_rst got=%b want=%b", ctl, C_RST); end
    tick();
    rst = 1'b1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL abort_cleared got=%b want=%b", ctl, C_RUN); end
    tick();
  endtask
`else
  task automatic test_fwd_alu;
    clear_in(); exe_rd = 5; exe_reg_we = 1; id_rs1 = 5; id_rs1_use = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL alu_run got=%b want=%b", ctl, C_RUN); end
    tick();
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL alu_fwd_a got=%b want=01", fwd_a); end
    clear_in(); mem_rd = 6; mem_reg_we = 1; id_rs2 = 6; id_rs2_use = 1; tick();
    total++; if (fwd_b !== 2'b10) begin bad++; $display("FAIL mem_fwd_b got=%b want=10", fwd_b); end
    clear_in(); exe_rd = 7; exe_reg_we = 1; mem_rd = 7; mem_reg_we = 1; id_rs1 = 7; id_rs1_use = 1; tick();
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL prio_fwd_a got=%b want=01", fwd_a); end
  endtask

  task automatic test_load_use;
    clear_in(); exe_rd = 5; exe_reg_we = 1; exe_is_load = 1; id_rs2 = 5; id_rs2_use = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL lu_stall got=%b want=%b", ctl, C_STALL); end
    tick();
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL lu_bubble_fwd got=%b want=00", fwd_b); end
    clear_in(); mem_rd = 5; mem_reg_we = 1; id_rs2 = 5; id_rs2_use = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL lu_run got=%b want=%b", ctl, C_RUN); end
    tick();
    total++; if (fwd_b !== 2'b10) begin bad++; $display("FAIL lu_fwd_b got=%b want=10", fwd_b); end
  endtask

  task automatic test_redirect;
    clear_in(); exe_rd = 5; exe_reg_we = 1; id_rs1 = 5; id_rs1_use = 1; tick();
    clear_in(); exe_rd = 5; exe_reg_we = 1; exe_is_load = 1; id_rs1 = 5; id_rs1_use = 1; br_taken = 1; #1;
    total++; if (redir !== C_REDIR) begin bad++; $display("FAIL redir_ctl got=%b want=%b", redir, C_REDIR); end
    tick();
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL redir_fwd got=%b want=00", fwd_a); end
  endtask

  task automatic test_freeze;
    clear_in(); exe_rd = 3; exe_reg_we = 1; id_rs1 = 3; id_rs1_use = 1; tick();
    for (int i = 0; i < 3; i++) begin
      clear_in(); exe_rd = 5; exe_reg_we = 1; exe_is_load = 1; id_rs2 = 5; id_rs2_use = 1; dmem_busy = 1; #1;
      total++; if (ctl !== C_FRZ) begin bad++; $display("FAIL frz_ctl%0d got=%b want=%b", i, ctl, C_FRZ); end
      tick();
      total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL frz_fwd%0d got=%b want=01", i, fwd_a); end
    end
    clear_in(); exe_rd = 5; exe_reg_we = 1; exe_is_load = 1; id_rs2 = 5; id_rs2_use = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL frz_then_stall got=%b want=%b", ctl, C_STALL); end
    tick();
    clear_in(); mem_rd = 5; mem_reg_we = 1; id_rs2 = 5; id_rs2_use = 1; #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL frz_then_run got=%b want=%b", ctl, C_RUN); end
    tick();
    total++; if (fwd_b !== 2'b10) begin bad++; $display("FAIL frz_fwd_b got=%b want=10", fwd_b); end
  endtask
`endif

  initial begin
    clear_in();
    rst = 1'b0;
    test_reset();
    test_x0();
`ifndef HAZARD_FORWARDING_EN
    test_sb_raw();
    test_sb_freeze();
    test_sb_redirect();
    test_sb_saturate();
    test_sb_underflow();
    test_sb_simul();
    test_reset_abort();
`else
    test_fwd_alu();
    test_load_use();
    test_redirect();
    test_freeze();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
